// File: rtl/iter_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : iter_multiplier_if
// Description : Request/result bundle between the LEGv8 control path and the
//               iterative multiplier (operands in, register-file write out).
// Revision    : 1.0 - initial release
// ============================================================================
interface iter_multiplier_if #(
    parameter int WIDTH = 64
);
    logic             Start;
    logic             Mode;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [4:0]       DestIn;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] WriteData;
    logic [4:0]       WriteRegister;
    logic             RegWrite;

    // Requester side: issues operations, observes completion.
    modport master (
        output Start, Mode, OpA, OpB, DestIn,
        input  Busy, Done, WriteData, WriteRegister, RegWrite
    );

    // Multiplier side.
    modport slave (
        input  Start, Mode, OpA, OpB, DestIn,
        output Busy, Done, WriteData, WriteRegister, RegWrite
    );
endinterface
`default_nettype wire

// File: rtl/iter_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : iter_multiplier
// Description : Radix-2 shift-add 64x64 multiplier with fixed latency.
//               Returns the low half (MUL) or unsigned high half (UMULH) of
//               the product as a register-file write.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_multiplier #(
    parameter int WIDTH = 64,
    parameter int STEPS = 64
) (
    input  wire               clk,
    input  wire               reset,
    iter_multiplier_if.slave  bus
);
    localparam int c_CNT_W = $clog2(STEPS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(STEPS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_mode;
    logic [4:0]         r_dest;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_a;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_wdata;
    logic [4:0]         r_wreg;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_nextHi;
    logic [WIDTH-1:0]   w_nextLo;

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, then shift the 129-bit {carry,Hi,Lo} right by one.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_nextHi = w_sum[WIDTH:1];
        w_nextLo = {w_sum[0], r_lo[WIDTH-1:1]};
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mode  <= 1'b0;
            r_dest  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_cnt   <= '0;
            r_wdata <= '0;
            r_wreg  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.Start) begin
                        r_mode  <= bus.Mode;
                        r_dest  <= bus.DestIn;
                        r_hi    <= '0;
                        r_lo    <= bus.OpB;
                        r_a     <= bus.OpA;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_hi  <= w_nextHi;
                    r_lo  <= w_nextLo;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    // Final step: publish straight from the step result so
                    // WriteData is valid during the Done cycle.
                    if (r_cnt == c_LAST) begin
                        r_wdata <= r_mode ? w_nextHi : w_nextLo;
                        r_wreg  <= r_dest;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy          = r_busy;
    assign bus.Done          = r_done;
    assign bus.RegWrite      = r_done;
    assign bus.WriteData     = r_wdata;
    assign bus.WriteRegister = r_wreg;
endmodule
`default_nettype wire

// File: tb/tb_iter_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_multiplier
// Description : Self-checking bench for iter_multiplier: cycle-level
//               reference model plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_multiplier;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   nVec  = 0;
    int   nErr  = 0;

    iter_multiplier_if #(.WIDTH(64)) bus ();

    iter_multiplier #(.WIDTH(64), .STEPS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: full 128-bit product, pick the requested half.
    function automatic logic [63:0] refMul(input logic [63:0] a, input logic [63:0] b,
                                           input logic m);
        logic [127:0] p;
        p = {64'b0, a} * {64'b0, b};
        return m ? p[127:64] : p[63:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: accept in idle, result after 64 busy cycles,
    // one-cycle done, outputs hold until next completion.
    logic        mBusy   = 1'b0;
    logic        mDone   = 1'b0;
    logic [63:0] mWd     = '0;
    logic [4:0]  mWr     = '0;
    logic [63:0] mRes    = '0;
    logic [4:0]  mDest   = '0;
    int          mRemain = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy <= 1'b0; mDone <= 1'b0; mWd <= '0; mWr <= '0; mRemain <= 0;
        end else if (mDone) begin
            mDone <= 1'b0;
        end else if (mBusy) begin
            if (mRemain == 1) begin
                mBusy <= 1'b0; mDone <= 1'b1; mWd <= mRes; mWr <= mDest;
            end
            mRemain <= mRemain - 1;
        end else if (bus.Start) begin
            mBusy   <= 1'b1;
            mRemain <= 64;
            mRes    <= refMul(bus.OpA, bus.OpB, bus.Mode);
            mDest   <= bus.DestIn;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("busy",     {63'b0, bus.Busy},          {63'b0, mBusy});
            check("done",     {63'b0, bus.Done},          {63'b0, mDone});
            check("regwrite", {63'b0, bus.RegWrite},      {63'b0, mDone});
            check("wdata",    bus.WriteData,              mWd);
            check("wreg",     {59'b0, bus.WriteRegister}, {59'b0, mWr});
        end
    end

    task automatic startOp(input logic [63:0] a, input logic [63:0] b,
                           input logic m, input logic [4:0] d);
        @(posedge clk); #1;
        bus.OpA = a; bus.OpB = b; bus.Mode = m; bus.DestIn = d; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        // Inputs after the accept edge must not matter.
        bus.OpA = ~a; bus.OpB = ~b; bus.Mode = ~m; bus.DestIn = ~d;
    endtask

    task automatic waitDone(input string name, input logic [63:0] expWd,
                            input logic [4:0] expWr, output int busyCnt);
        bit seen = 0;
        busyCnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.Done) begin seen = 1; break; end
            if (bus.Busy) busyCnt++;
        end
        check({name, "_done_seen"}, {63'b0, seen}, 64'd1);
        check({name, "_wdata"}, bus.WriteData, expWd);
        check({name, "_wreg"}, {59'b0, bus.WriteRegister}, {59'b0, expWr});
        check({name, "_regwrite"}, {63'b0, bus.RegWrite}, 64'd1);
    endtask

    task automatic countDone(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.RegWrite || bus.Done) n++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, nErr=%0d", nErr);
        $fatal(1);
    end

    initial begin
        int bc;
        int nd;
        bus.Start = 1'b0; bus.Mode = 1'b0; bus.OpA = '0; bus.OpB = '0; bus.DestIn = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy",  {63'b0, bus.Busy}, 64'd0);
        check("rst_done",  {63'b0, bus.Done}, 64'd0);
        check("rst_wdata", bus.WriteData, 64'd0);
        check("rst_wreg",  {59'b0, bus.WriteRegister}, 64'd0);

        startOp(64'd3, 64'd5, 1'b0, 5'd7);
        waitDone("mul3x5", 64'd15, 5'd7, bc);
        check("mul3x5_busy_cycles", 64'(bc), 64'd64);
        @(negedge clk);
        check("mul3x5_done_one_cycle", {63'b0, bus.Done}, 64'd0);

        startOp(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd1);
        waitDone("umulh_ones", 64'hFFFF_FFFF_FFFF_FFFE, 5'd1, bc);
        startOp(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd1);
        waitDone("mul_ones", 64'h0000_0000_0000_0001, 5'd1, bc);
        startOp(64'h0000_0102_0408_0001, 64'd3, 1'b0, 5'd3);
        waitDone("mul_pattern", 64'h0000_0306_0C18_0003, 5'd3, bc);
        startOp(64'hA0, 64'd0, 1'b0, 5'd5);
        waitDone("mul_zero", 64'd0, 5'd5, bc);
        startOp(64'h8000_0000_0000_0000, 64'd4, 1'b1, 5'd6);
        waitDone("umulh_shift", 64'd2, 5'd6, bc);

        // Second request while busy is ignored.
        startOp(64'd5, 64'd6, 1'b0, 5'd2);
        repeat (8) @(posedge clk);
        #1 bus.OpA = 64'd9; bus.OpB = 64'd9; bus.DestIn = 5'd4; bus.Mode = 1'b0; bus.Start = 1'b1;
        @(posedge clk); #1 bus.Start = 1'b0;
        waitDone("ignore_start", 64'd30, 5'd2, bc);
        countDone(70, nd);
        check("ignore_start_no_second_done", 64'(nd), 64'd0);

        // Asynchronous reset mid-run.
        startOp(64'd11, 64'd13, 1'b0, 5'd9);
        repeat (29) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_busy", {63'b0, bus.Busy}, 64'd0);
        check("async_rst_wdata", bus.WriteData, 64'd0);
        #3 reset = 1'b0;
        countDone(70, nd);
        check("async_rst_no_regwrite", 64'(nd), 64'd0);
        startOp(64'd2, 64'd2, 1'b0, 5'd8);
        waitDone("after_rst", 64'd4, 5'd8, bc);

        startOp(64'd7, 64'd8, 1'b0, 5'd31);
        waitDone("dest31", 64'd56, 5'd31, bc);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
`default_nettype wire
